ddr_arbiter: RTL and testbench
==============================

DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, max consecutive video grants while a Life request waits.
REQ-002 Parameter AW, default 23, word address width.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 vidReq  in  1  frame-buffer read request (VGA line prefetch).
REQ-006 vidAddr  in  AW  video read address.
REQ-007 vidGnt  out  1  one-cycle pulse: video request taken.
REQ-008 vidDone  out  1  one-cycle pulse: video read data valid on rdDataOut.
REQ-009 golReq  in  1  Game-of-Life access request.
REQ-010 golWe  in  1  1 = write, 0 = read.
REQ-011 golAddr  in  AW  Life access address.
REQ-012 golWrData  in  32  Life write data.
REQ-013 golGnt  out  1  one-cycle pulse: Life request taken.
REQ-014 golDone  out  1  one-cycle pulse: Life access complete (read data on rdDataOut).
REQ-015 refreshTick  in  1  one-cycle pulse from refresh interval timer.
REQ-016 refMissed  out  1  sticky: tick arrived while refresh already pending.
REQ-017 memCmd  out  2  00 none, 01 read, 10 write, 11 auto-refresh.
REQ-018 memAddr  out  AW / memWrData  out  32  latched command operands.
REQ-019 memValid  out  1  command valid; memReady  in  1  DDR controller accepts.
REQ-020 memDone  in  1  pulse: command finished; memRdData  in  32  read data with memDone.
REQ-021 rdDataOut  out  32 / busy  out  1  (busy = state != IDLE).

Function
REQ-022 States: IDLE, ISSUE, WAIT; all registered, gnt/done outputs registered.
REQ-023 IDLE: arbitrate among refresh (refPending|refreshTick), video, Life; on winner, latch memCmd/memAddr/memWrData, go ISSUE next cycle.
REQ-024 Priority: refresh > video > Life, except Life beats video when starveCnt == STARVE_LIMIT.
REQ-025 starveCnt: +1 when video wins while golReq=1; cleared when Life wins or golReq=0; saturates at STARVE_LIMIT.
REQ-026 Grant latency: request sampled in IDLE at cycle N -> gnt pulse and memValid=1 at N+1; requester drops or changes req from N+2.
REQ-027 Refresh has no gnt; refPending set by refreshTick, cleared when refresh command latched; tick in same cycle as clear re-sets pending.
REQ-028 refreshTick while refPending=1 sets refMissed (cleared only by rst).
REQ-029 ISSUE: hold memValid and operands stable until memReady=1; then memValid=0, go WAIT.
REQ-030 WAIT: on memDone, register memRdData into rdDataOut, pulse owner's done next cycle (none for refresh), go IDLE.
REQ-031 memDone in IDLE/ISSUE ignored; memReady in IDLE/WAIT ignored.
REQ-032 Back-to-back: IDLE re-entered the cycle after done pulse; minimum 4 cycles per access with memReady/memDone immediate.
REQ-033 memCmd=00 and memValid=0 whenever state is IDLE.

Reset
REQ-034 rst at any cycle (including ISSUE/WAIT) forces IDLE next cycle; in-flight access abandoned, no done pulse.
REQ-035 Reset values: all outputs 0, memCmd=00, rdDataOut=0, starveCnt=0, refPending=0, refMissed=0.
REQ-036 refreshTick and requests in a cycle with rst=1 are ignored.

Verification
REQ-037 vidReq=1, vidAddr=0x000100, memReady/memDone tied 1 -> vidGnt at N+1, memCmd=01, memAddr=0x000100, vidDone 3 cycles later with rdDataOut=memRdData.
REQ-038 vidReq, golReq, refreshTick same IDLE cycle -> memCmd=11 first, then video, then Life; no gnt for refresh.
REQ-039 vidReq and golReq held high continuously -> exactly 8 video grants, then 1 Life grant, pattern repeats.
REQ-040 Two refreshTicks with memReady=0 between -> refMissed=1, single refresh issued once memReady=1.
REQ-041 golWe=1, golWrData=0xDEADBEEF, memReady low 5 cycles -> memValid/operands stable 5 cycles, memCmd=10, golDone after memDone.
REQ-042 rst asserted in WAIT -> IDLE, busy=0, all outputs 0 next cycle; later memDone produces no done pulse.

Source files
------------

// File: rtl/ddr_arbiter.sv
// DDR access arbiter: refresh, VGA frame-buffer reads and Game-of-Life
// accesses share one DDR controller port. One command is in flight at a time.
// Sequence per access: IDLE (arbitrate, latch) -> ISSUE (hold until accepted)
// -> WAIT (capture read data, pulse done, then one more WAIT cycle) -> IDLE,
// so an access with immediate memReady/memDone occupies four cycles.
module ddr_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vidReq,
    input  logic [AW-1:0] vidAddr,
    output logic          vidGnt,
    output logic          vidDone,
    input  logic          golReq,
    input  logic          golWe,
    input  logic [AW-1:0] golAddr,
    input  logic [31:0]   golWrData,
    output logic          golGnt,
    output logic          golDone,
    input  logic          refreshTick,
    output logic          refMissed,
    output logic [1:0]    memCmd,
    output logic [AW-1:0] memAddr,
    output logic [31:0]   memWrData,
    output logic          memValid,
    input  logic          memReady,
    input  logic          memDone,
    input  logic [31:0]   memRdData,
    output logic [31:0]   rdDataOut,
    output logic          busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_GOL, OWN_REF} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            doneSeen_q, doneSeen_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            refPending_q, refPending_d;
    logic            refMissed_q, refMissed_d;
    logic [1:0]      memCmd_q, memCmd_d;
    logic [AW-1:0]   memAddr_q, memAddr_d;
    logic [31:0]     memWrData_q, memWrData_d;
    logic            memValid_q, memValid_d;
    logic            vidGnt_q, vidGnt_d;
    logic            golGnt_q, golGnt_d;
    logic            vidDone_q, vidDone_d;
    logic            golDone_q, golDone_d;
    logic [31:0]     rdData_q, rdData_d;
    logic            ref_latch;
    logic            ref_want;
    logic            gol_first;

    // Arbitration, command sequencing, refresh bookkeeping and starvation count
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        doneSeen_d   = doneSeen_q;
        starve_d     = starve_q;
        memCmd_d     = memCmd_q;
        memAddr_d    = memAddr_q;
        memWrData_d  = memWrData_q;
        memValid_d   = memValid_q;
        rdData_d     = rdData_q;
        vidGnt_d     = 1'b0;
        golGnt_d     = 1'b0;
        vidDone_d    = 1'b0;
        golDone_d    = 1'b0;
        ref_latch    = 1'b0;
        ref_want     = refPending_q | refreshTick;
        gol_first    = (starve_q == SW'(STARVE_LIMIT));

        case (state_q)
            S_IDLE: begin
                memCmd_d   = CMD_NONE;
                memValid_d = 1'b0;
                if (ref_want) begin
                    ref_latch  = 1'b1;
                    owner_d    = OWN_REF;
                    memCmd_d   = CMD_REF;
                    memValid_d = 1'b1;
                    state_d    = S_ISSUE;
                end else if (golReq && (gol_first || !vidReq)) begin
                    owner_d     = OWN_GOL;
                    memCmd_d    = golWe ? CMD_WRITE : CMD_READ;
                    memAddr_d   = golAddr;
                    memWrData_d = golWrData;
                    memValid_d  = 1'b1;
                    golGnt_d    = 1'b1;
                    starve_d    = '0;
                    state_d     = S_ISSUE;
                end else if (vidReq) begin
                    owner_d    = OWN_VID;
                    memCmd_d   = CMD_READ;
                    memAddr_d  = vidAddr;
                    memValid_d = 1'b1;
                    vidGnt_d   = 1'b1;
                    if (golReq && !gol_first) begin
                        starve_d = starve_q + SW'(1);
                    end
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (memReady) begin
                    memValid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (doneSeen_q) begin
                    // Done pulse is on the outputs this cycle; release next.
                    doneSeen_d = 1'b0;
                    owner_d    = OWN_NONE;
                    memCmd_d   = CMD_NONE;
                    state_d    = S_IDLE;
                end else if (memDone) begin
                    rdData_d   = memRdData;
                    doneSeen_d = 1'b1;
                    vidDone_d  = (owner_q == OWN_VID);
                    golDone_d  = (owner_q == OWN_GOL);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!golReq) begin
            starve_d = '0;
        end

        // A tick that itself triggered the refresh is consumed; a tick on top
        // of an already-pending refresh that is being latched re-arms it.
        refPending_d = (refPending_q & ~ref_latch)
                     | (refreshTick & ~(ref_latch & ~refPending_q));
        refMissed_d  = refMissed_q | (refreshTick & refPending_q);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            doneSeen_q   <= 1'b0;
            starve_q     <= '0;
            refPending_q <= 1'b0;
            refMissed_q  <= 1'b0;
            memCmd_q     <= CMD_NONE;
            memAddr_q    <= '0;
            memWrData_q  <= '0;
            memValid_q   <= 1'b0;
            vidGnt_q     <= 1'b0;
            golGnt_q     <= 1'b0;
            vidDone_q    <= 1'b0;
            golDone_q    <= 1'b0;
            rdData_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            doneSeen_q   <= doneSeen_d;
            starve_q     <= starve_d;
            refPending_q <= refPending_d;
            refMissed_q  <= refMissed_d;
            memCmd_q     <= memCmd_d;
            memAddr_q    <= memAddr_d;
            memWrData_q  <= memWrData_d;
            memValid_q   <= memValid_d;
            vidGnt_q     <= vidGnt_d;
            golGnt_q     <= golGnt_d;
            vidDone_q    <= vidDone_d;
            golDone_q    <= golDone_d;
            rdData_q     <= rdData_d;
        end
    end

    assign vidGnt    = vidGnt_q;
    assign golGnt    = golGnt_q;
    assign vidDone   = vidDone_q;
    assign golDone   = golDone_q;
    assign refMissed = refMissed_q;
    assign memCmd    = memCmd_q;
    assign memAddr   = memAddr_q;
    assign memWrData = memWrData_q;
    assign memValid  = memValid_q;
    assign rdDataOut = rdData_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter with a command/done scoreboard.
module tb_ddr_arbiter;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          vidReq;
    logic [AW-1:0] vidAddr;
    logic          vidGnt, vidDone;
    logic          golReq, golWe;
    logic [AW-1:0] golAddr;
    logic [31:0]   golWrData;
    logic          golGnt, golDone;
    logic          refreshTick, refMissed;
    logic [1:0]    memCmd;
    logic [AW-1:0] memAddr;
    logic [31:0]   memWrData;
    logic          memValid, memReady, memDone;
    logic [31:0]   memRdData, rdDataOut;
    logic          busy;

    always #5 clk = ~clk;

    ddr_arbiter #(.STARVE_LIMIT(8), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .vidReq(vidReq), .vidAddr(vidAddr), .vidGnt(vidGnt), .vidDone(vidDone),
        .golReq(golReq), .golWe(golWe), .golAddr(golAddr), .golWrData(golWrData),
        .golGnt(golGnt), .golDone(golDone),
        .refreshTick(refreshTick), .refMissed(refMissed),
        .memCmd(memCmd), .memAddr(memAddr), .memWrData(memWrData),
        .memValid(memValid), .memReady(memReady), .memDone(memDone),
        .memRdData(memRdData), .rdDataOut(rdDataOut), .busy(busy)
    );

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          vg;
        logic          gg;
    } cmd_t;

    typedef struct {
        logic        vd;
        logic        gd;
        logic [31:0] data;
    } done_t;

    cmd_t  exp_cmd_q[$];
    done_t exp_done_q[$];
    cmd_t  cur;
    done_t dexp;
    logic  prev_valid = 1'b0;
    int    checks = 0;
    int    passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_cmd(input logic [1:0] c, input logic [AW-1:0] a,
                            input logic [31:0] w, input logic v, input logic g);
        cmd_t e;
        e.cmd = c; e.addr = a; e.wd = w; e.vg = v; e.gg = g;
        exp_cmd_q.push_back(e);
    endtask

    task automatic push_done(input logic v, input logic g, input logic [31:0] d);
        done_t e;
        e.vd = v; e.gd = g; e.data = d;
        exp_done_q.push_back(e);
    endtask

    // One clock: sample after the edge, then score commands and done pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (memValid && !prev_valid) begin
            if (exp_cmd_q.size() == 0) begin
                check("unexpected_cmd", 64'(memCmd), 64'(0));
            end else begin
                cur = exp_cmd_q.pop_front();
                $display("cmd issued: memCmd=%b addr=0x%06h wd=0x%08h vidGnt=%0b golGnt=%0b",
                         memCmd, memAddr, memWrData, vidGnt, golGnt);
                check("cmd_code", 64'(memCmd), 64'(cur.cmd));
                if (cur.cmd != 2'b11) check("cmd_addr", 64'(memAddr), 64'(cur.addr));
                if (cur.cmd == 2'b10) check("cmd_wdata", 64'(memWrData), 64'(cur.wd));
                check("cmd_gnt", 64'({vidGnt, golGnt}), 64'({cur.vg, cur.gg}));
            end
        end else begin
            check("stray_gnt", 64'({vidGnt, golGnt}), 64'(0));
            if (memValid) begin
                check("hold_cmd", 64'(memCmd), 64'(cur.cmd));
                if (cur.cmd != 2'b11) check("hold_addr", 64'(memAddr), 64'(cur.addr));
            end
        end
        prev_valid = memValid;
        if (vidDone || golDone) begin
            if (exp_done_q.size() == 0) begin
                check("stray_done", 64'({vidDone, golDone}), 64'(0));
            end else begin
                dexp = exp_done_q.pop_front();
                $display("done: vidDone=%0b golDone=%0b rdDataOut=0x%08h",
                         vidDone, golDone, rdDataOut);
                check("done_owner", 64'({vidDone, golDone}), 64'({dexp.vd, dexp.gd}));
                check("done_data", 64'(rdDataOut), 64'(dexp.data));
            end
        end
        if (!busy) check("idle_cmd_valid", 64'({memCmd, memValid}), 64'(0));
    endtask

    // Hold requests until the given numbers of grants have been seen.
    task automatic run_reqs(input int nv, input int ng, input int max_cycles);
        int vl, gl;
        vl = nv; gl = ng;
        vidReq = (vl > 0);
        golReq = (gl > 0);
        for (int i = 0; i < max_cycles; i++) begin
            step();
            refreshTick = 1'b0;
            if (vidGnt && vl > 0) vl--;
            if (golGnt && gl > 0) gl--;
            if (vl == 0) vidReq = 1'b0;
            if (gl == 0) golReq = 1'b0;
            if (vl == 0 && gl == 0) break;
        end
        check("grants_vid_left", 64'(vl), 64'(0));
        check("grants_gol_left", 64'(gl), 64'(0));
    endtask

    // Step until idle with an empty scoreboard, bounded.
    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy && exp_cmd_q.size() == 0 && exp_done_q.size() == 0) break;
            step();
        end
        check("drain_cmdq", 64'(exp_cmd_q.size()), 64'(0));
        check("drain_doneq", 64'(exp_done_q.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        vidReq = 1'b0; vidAddr = '0;
        golReq = 1'b0; golWe = 1'b0; golAddr = '0; golWrData = '0;
        refreshTick = 1'b0;
        memReady = 1'b1; memDone = 1'b1; memRdData = 32'h0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_outs", 64'({vidGnt, vidDone, golGnt, golDone, refMissed, memValid, memCmd}), 64'(0));
        check("rst_rd_addr", 64'({rdDataOut, memAddr}), 64'(0));
        check("rst_wdata", 64'(memWrData), 64'(0));
        rst = 1'b0;
        step();

        // Single video read, immediate ready/done: exact cycle timing
        memRdData = 32'hCAFE_0001;
        vidAddr = 23'h000100;
        vidReq = 1'b1;
        push_cmd(2'b01, 23'h000100, 32'h0, 1'b1, 1'b0);
        push_done(1'b1, 1'b0, 32'hCAFE_0001);
        step();
        check("t1_gnt", 64'({vidGnt, memValid}), 64'(2'b11));
        vidReq = 1'b0;
        step();
        check("t1_wait", 64'({busy, memValid}), 64'(2'b10));
        step();
        check("t1_done", 64'(vidDone), 64'(1));
        check("t1_rd", 64'(rdDataOut), 64'(32'hCAFE_0001));
        step();
        check("t1_idle", 64'({busy, vidDone, memCmd}), 64'(0));

        // Simultaneous refresh, video and Life: refresh, then video, then Life
        memRdData = 32'h1111_2222;
        vidAddr = 23'h000200; golAddr = 23'h000300; golWe = 1'b0;
        refreshTick = 1'b1;
        push_cmd(2'b11, 23'h0, 32'h0, 1'b0, 1'b0);
        push_cmd(2'b01, 23'h000200, 32'h0, 1'b1, 1'b0);
        push_cmd(2'b01, 23'h000300, 32'h0, 1'b0, 1'b1);
        push_done(1'b1, 1'b0, 32'h1111_2222);
        push_done(1'b0, 1'b1, 32'h1111_2222);
        run_reqs(1, 1, 40);
        drain(20);

        // Both held: 8 video grants then one Life grant, twice
        memRdData = 32'h3333_4444;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                push_cmd(2'b01, 23'h000200, 32'h0, 1'b1, 1'b0);
                push_done(1'b1, 1'b0, 32'h3333_4444);
            end
            push_cmd(2'b01, 23'h000300, 32'h0, 1'b0, 1'b1);
            push_done(1'b0, 1'b1, 32'h3333_4444);
        end
        run_reqs(16, 2, 120);
        drain(20);

        // Two ticks while stalled on memReady: refMissed, a single refresh later
        memReady = 1'b0;
        memRdData = 32'h5555_6666;
        vidAddr = 23'h000440;
        push_cmd(2'b01, 23'h000440, 32'h0, 1'b1, 1'b0);
        push_done(1'b1, 1'b0, 32'h5555_6666);
        push_cmd(2'b11, 23'h0, 32'h0, 1'b0, 1'b0);
        run_reqs(1, 0, 4);
        refreshTick = 1'b1;
        step();
        refreshTick = 1'b0;
        check("t4_missed0", 64'(refMissed), 64'(0));
        step();
        step();
        refreshTick = 1'b1;
        step();
        refreshTick = 1'b0;
        check("t4_missed1", 64'(refMissed), 64'(1));
        memReady = 1'b1;
        drain(30);
        for (int i = 0; i < 6; i++) step();
        check("t4_missed_sticky", 64'(refMissed), 64'(1));

        // Life write with memReady held low for 5 cycles
        memReady = 1'b0;
        memRdData = 32'h7777_8888;
        golWe = 1'b1; golAddr = 23'h001234; golWrData = 32'hDEAD_BEEF;
        push_cmd(2'b10, 23'h001234, 32'hDEAD_BEEF, 1'b0, 1'b1);
        push_done(1'b0, 1'b1, 32'h7777_8888);
        run_reqs(0, 1, 4);
        golAddr = 23'h7FFFFF; golWrData = 32'h0; golWe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold", 64'({memValid, memCmd, memAddr}), 64'({1'b1, 2'b10, 23'h001234}));
            check("t5_hold_wd", 64'(memWrData), 64'(32'hDEAD_BEEF));
            step();
        end
        memReady = 1'b1;
        drain(20);

        // Reset in WAIT abandons the access; requests/ticks during reset ignored
        memDone = 1'b0;
        vidAddr = 23'h000500;
        push_cmd(2'b01, 23'h000500, 32'h0, 1'b1, 1'b0);
        run_reqs(1, 0, 4);
        step();
        check("t6_in_wait", 64'({busy, memValid}), 64'(2'b10));
        rst = 1'b1;
        vidReq = 1'b1;
        refreshTick = 1'b1;
        step();
        rst = 1'b0;
        vidReq = 1'b0;
        refreshTick = 1'b0;
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_outs", 64'({vidGnt, vidDone, golGnt, golDone, refMissed, memValid, memCmd}), 64'(0));
        check("t6_rst_rd", 64'(rdDataOut), 64'(0));
        memDone = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_no_done", 64'({vidDone, golDone, busy}), 64'(0));
        end
        drain(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
